// File: rtl/uart_tx_frame_engine_if.sv
// Parallel-side bundle of the UART TX frame engine: request, frame options and line/status outputs.
interface uart_tx_frame_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 16
) ();
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  STOP2;
   logic [PRESC_W-1:0]    baud_div;
   logic                  TX_OUT;
   logic                  busy;
   logic                  tx_done;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, baud_div,
      input  TX_OUT, busy, tx_done
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, baud_div,
      output TX_OUT, busy, tx_done
   );
endinterface

// File: rtl/uart_tx_frame_engine.sv
// UART transmitter: frame sequencing, LSB-first serialization, parity and baud timing in one block.
// Frame options are latched on acceptance, so inputs may change freely while a frame is in flight.
module uart_tx_frame_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 16
) (
   input logic               clk,
   input logic               RST,
   uart_tx_frame_engine_if.slave bus
);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] START   = 3'd1;
   localparam logic [2:0] DATA    = 3'd2;
   localparam logic [2:0] PARITY  = 3'd3;
   localparam logic [2:0] STOP1   = 3'd4;
   localparam logic [2:0] STOP2_S = 3'd5;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   logic [2:0]            state, state_nxt;
   logic [PRESC_W-1:0]    baud_cnt;
   logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q, par_typ_q, stop2_q;
   logic [PRESC_W-1:0]    div_q;
   logic                  tx_q, busy_q, done_q;
   logic                  bit_end, accept, line_nxt;

   always_comb begin
      bit_end     = (baud_cnt == div_q);
      accept      = (state == IDLE) && bus.Data_Valid;
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      case (state)
         IDLE:    if (accept) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_IDX) begin
                  bit_idx_nxt = '0;
                  state_nxt   = par_en_q ? PARITY : STOP1;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         PARITY:  if (bit_end) state_nxt = STOP1;
         STOP1:   if (bit_end) state_nxt = stop2_q ? STOP2_S : IDLE;
         STOP2_S: if (bit_end) state_nxt = IDLE;
         default: begin
            state_nxt   = IDLE;
            bit_idx_nxt = '0;
         end
      endcase
   end

   // Line level is decoded from the next state/index so TX_OUT changes on the same edge as the state.
   always_comb begin
      line_nxt = 1'b1;
      case (state_nxt)
         START:   line_nxt = 1'b0;
         DATA:    line_nxt = data_q[bit_idx_nxt];
         PARITY:  line_nxt = (^data_q) ^ par_typ_q;
         default: line_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         stop2_q   <= 1'b0;
         div_q     <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_idx_nxt;
         if (state == IDLE || state_nxt != state || bit_end)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + PRESC_W'(1);
         if (accept) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            stop2_q   <= bus.STOP2;
            div_q     <= bus.baud_div;
         end
         tx_q   <= line_nxt;
         busy_q <= (state_nxt != IDLE);
         done_q <= ((state == STOP1) || (state == STOP2_S)) && (state_nxt == IDLE);
      end
   end

   assign bus.TX_OUT  = tx_q;
   assign bus.busy    = busy_q;
   assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Scoreboard bench for uart_tx_frame_engine: stimulus queues hand-computed bit strings,
// a monitor checks every line cycle of each frame plus the done pulse and idle gap.
module tb_uart_tx_frame_engine;
   logic clk = 1'b0;
   logic RST = 1'b1;
   always #5 clk = ~clk;

   uart_tx_frame_engine_if #(.DATA_WIDTH(8), .PRESC_W(16)) b8 ();
   uart_tx_frame_engine_if #(.DATA_WIDTH(5), .PRESC_W(16)) b5 ();

   uart_tx_frame_engine #(.DATA_WIDTH(8), .PRESC_W(16)) dut8 (.clk(clk), .RST(RST), .bus(b8));
   uart_tx_frame_engine #(.DATA_WIDTH(5), .PRESC_W(16)) dut5 (.clk(clk), .RST(RST), .bus(b5));

   logic sel = 1'b0;
   logic m_tx, m_busy, m_done;
   assign m_tx   = sel ? b5.TX_OUT  : b8.TX_OUT;
   assign m_busy = sel ? b5.busy    : b8.busy;
   assign m_done = sel ? b5.tx_done : b8.tx_done;

   typedef struct {
      logic [31:0] bits;
      int unsigned nbits;
      int unsigned bitlen;
      int unsigned abort_at;
      bit          b2b;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   in_frame = 1'b0;
   bit   must_start = 1'b0;

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   // bit string is in transmission order: s[0] is the start bit
   task automatic expect_frame(input string s, input int unsigned bitlen,
                               input int unsigned abort_at, input bit b2b);
      exp_t e;
      e.bits = '0;
      e.nbits = s.len();
      for (int i = 0; i < s.len(); i++) e.bits[i] = (s[i] == 8'h31);
      e.bitlen = bitlen;
      e.abort_at = abort_at;
      e.b2b = b2b;
      q.push_back(e);
   endtask

   task automatic send8(input logic [7:0] d, input logic pe, input logic pt,
                        input logic s2, input logic [15:0] div);
      b8.P_DATA = d; b8.PAR_EN = pe; b8.PAR_TYP = pt; b8.STOP2 = s2; b8.baud_div = div;
      b8.Data_Valid = 1'b1;
      @(negedge clk);
      b8.Data_Valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while ((q.size() != 0 || in_frame) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || in_frame) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s actual=pending(%0d) required=drained", name, q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_done !== 1'b1 && n < 500);
      if (m_done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL timeout_done actual=%b required=1", m_done);
      end
   endtask

   initial begin : monitor
      exp_t e;
      bit aborted;
      forever begin
         @(negedge clk);
         if (m_busy !== 1'b1) begin
            if (must_start) chk("b2b_gap_start", m_busy, 1'b1);
            must_start = 1'b0;
            chk("idle_tx", m_tx, 1'b1);
            chk("idle_done", m_done, 1'b0);
         end else if (q.size() == 0) begin
            must_start = 1'b0;
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=busy required=idle at %0t", $time);
            for (int i = 0; i < 2000 && m_busy === 1'b1; i++) @(negedge clk);
         end else begin
            must_start = 1'b0;
            e = q.pop_front();
            in_frame = 1'b1;
            aborted = 1'b0;
            for (int unsigned c = 0; c < e.nbits * e.bitlen; c++) begin
               if (c != 0) @(negedge clk);
               if (e.abort_at != 0 && c == e.abort_at) begin
                  chk("abort_tx", m_tx, 1'b1);
                  chk("abort_busy", m_busy, 1'b0);
                  chk("abort_done", m_done, 1'b0);
                  aborted = 1'b1;
                  break;
               end
               chk("frame_tx", m_tx, e.bits[c / e.bitlen]);
               chk("frame_busy", m_busy, 1'b1);
               chk("frame_done", m_done, 1'b0);
            end
            if (!aborted) begin
               @(negedge clk);
               chk("end_busy", m_busy, 1'b0);
               chk("end_done", m_done, 1'b1);
               chk("end_tx", m_tx, 1'b1);
               must_start = e.b2b;
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : stimulus
      b8.P_DATA = '0; b8.Data_Valid = 1'b0; b8.PAR_EN = 1'b0; b8.PAR_TYP = 1'b0;
      b8.STOP2 = 1'b0; b8.baud_div = '0;
      b5.P_DATA = '0; b5.Data_Valid = 1'b0; b5.PAR_EN = 1'b0; b5.PAR_TYP = 1'b0;
      b5.STOP2 = 1'b0; b5.baud_div = '0;
      RST = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_tx", b8.TX_OUT, 1'b1);
      chk("reset_busy", b8.busy, 1'b0);
      chk("reset_done", b8.tx_done, 1'b0);

      // reset wins over a simultaneous request
      b8.Data_Valid = 1'b1;
      @(negedge clk);
      chk("reset_vs_valid_busy", b8.busy, 1'b0);
      RST = 1'b0;
      b8.Data_Valid = 1'b0;
      repeat (2) @(negedge clk);

      // 0xA5, even parity, one stop, 4 clk/bit
      expect_frame("01010010101", 4, 0, 1'b0);
      send8(8'hA5, 1'b1, 1'b0, 1'b0, 16'd3);
      wait_idle("basic");

      // 0x00, odd parity, two stops, 1 clk/bit
      expect_frame("000000000111", 1, 0, 1'b0);
      send8(8'h00, 1'b1, 1'b1, 1'b1, 16'd0);
      wait_idle("odd_2stop");

      // 0x3C, no parity, 3 clk/bit; inputs disturbed mid-frame
      expect_frame("0001111001", 3, 0, 1'b0);
      send8(8'h3C, 1'b0, 1'b0, 1'b0, 16'd2);
      repeat (4) @(negedge clk);
      b8.P_DATA = 8'hFF; b8.baud_div = 16'd0; b8.PAR_EN = 1'b1; b8.STOP2 = 1'b1;
      b8.Data_Valid = 1'b1;
      repeat (2) @(negedge clk);
      b8.Data_Valid = 1'b0;
      wait_idle("isolation");

      // 0x81, odd parity, held request: three frames with a one-cycle gap
      expect_frame("01000000111", 2, 0, 1'b1);
      expect_frame("01000000111", 2, 0, 1'b1);
      expect_frame("01000000111", 2, 0, 1'b0);
      b8.P_DATA = 8'h81; b8.PAR_EN = 1'b1; b8.PAR_TYP = 1'b1; b8.STOP2 = 1'b0;
      b8.baud_div = 16'd1; b8.Data_Valid = 1'b1;
      wait_done();
      wait_done();
      @(negedge clk);
      b8.Data_Valid = 1'b0;
      wait_idle("back_to_back");

      // 0x5A aborted by reset in data bit 3, then 0xC3 accepted right after
      expect_frame("00101101001", 4, 18, 1'b0);
      expect_frame("011000011011", 1, 0, 1'b0);
      b8.P_DATA = 8'h5A; b8.PAR_EN = 1'b1; b8.PAR_TYP = 1'b0; b8.STOP2 = 1'b0;
      b8.baud_div = 16'd3; b8.Data_Valid = 1'b1;
      @(negedge clk);
      b8.Data_Valid = 1'b0;
      repeat (17) @(negedge clk);
      RST = 1'b1;
      @(negedge clk);
      RST = 1'b0;
      b8.P_DATA = 8'hC3; b8.PAR_EN = 1'b1; b8.PAR_TYP = 1'b0; b8.STOP2 = 1'b1;
      b8.baud_div = 16'd0; b8.Data_Valid = 1'b1;
      @(negedge clk);
      b8.Data_Valid = 1'b0;
      wait_idle("reset_mid_frame");

      // 5-bit instance: 5'b10011, no parity, 2 clk/bit
      sel = 1'b1;
      @(negedge clk);
      expect_frame("0110011", 2, 0, 1'b0);
      b5.P_DATA = 5'b10011; b5.PAR_EN = 1'b0; b5.PAR_TYP = 1'b0; b5.STOP2 = 1'b0;
      b5.baud_div = 16'd1; b5.Data_Valid = 1'b1;
      @(negedge clk);
      b5.Data_Valid = 1'b0;
      wait_idle("width5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
